// File: rtl/times_table_divider_if.sv
// times_table_divider_if: request/result bundle between a requester and times_table_divider
//   enable    requester -> divider  synchronous clock enable
//   start     requester -> divider  division request
//   product   requester -> divider  dividend (WIDTH_P bits)
//   divisor   requester -> divider  divisor (WIDTH_D bits)
//   busy      divider -> requester  division in progress
//   done      divider -> requester  one-enabled-cycle result strobe
//   quotient  divider -> requester  product / divisor
//   remainder divider -> requester  product % divisor
//   div_zero  divider -> requester  last accepted request had divisor 0
interface times_table_divider_if #(
    parameter int WIDTH_P = 6,
    parameter int WIDTH_D = 3
);
    logic               enable;
    logic               start;
    logic [WIDTH_P-1:0] product;
    logic [WIDTH_D-1:0] divisor;
    logic               busy;
    logic               done;
    logic [WIDTH_P-1:0] quotient;
    logic [WIDTH_D-1:0] remainder;
    logic               div_zero;
    modport master (
        output enable, start, product, divisor,
        input  busy, done, quotient, remainder, div_zero
    );
    modport slave (
        input  enable, start, product, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/times_table_divider.sv
// times_table_divider: sequential restoring divider recovering a and remainder from a times-table product
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    times_table_divider_if.slave: enable/start/product/divisor in,
//          busy/done/quotient/remainder/div_zero out
module times_table_divider #(
    parameter int WIDTH_P = 6,
    parameter int WIDTH_D = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    times_table_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH_P + 1);
    typedef enum logic [1:0] {IDLE, CALC, ZERO} state_t;
    state_t             r_state;
    state_t             w_state_n;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH_P-1:0] r_dvd;
    logic [WIDTH_D-1:0] r_dsr;
    logic [WIDTH_D-1:0] r_rem;
    logic [WIDTH_P-1:0] r_quot;
    logic [WIDTH_D-1:0] r_remo;
    logic               r_dz;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH_D:0]   w_part;
    logic               w_ge;
    logic [WIDTH_D-1:0] w_rem_n;
    logic [WIDTH_P-1:0] w_dvd_n;
    logic               w_last;
    // The dividend register shifts left each iteration and collects quotient bits at its LSB,
    // so after WIDTH_P iterations it holds the quotient.
    assign w_part  = {r_rem, r_dvd[WIDTH_P-1]};
    assign w_ge    = w_part >= {1'b0, r_dsr};
    // The difference is always below the divisor, so only the low WIDTH_D bits matter.
    assign w_rem_n = w_ge ? w_part[WIDTH_D-1:0] - r_dsr : w_part[WIDTH_D-1:0];
    assign w_dvd_n = {r_dvd[WIDTH_P-2:0], w_ge};
    assign w_last  = r_cnt == CW'(1);
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_n = (bus.divisor == '0) ? ZERO : CALC;
            CALC:    if (w_last) w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else if (bus.enable) r_state <= w_state_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_dvd  <= '0;
            r_dsr  <= '0;
            r_rem  <= '0;
            r_quot <= '0;
            r_remo <= '0;
            r_dz   <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (bus.enable) begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.start) begin
                    r_dvd  <= bus.product;
                    r_dsr  <= bus.divisor;
                    r_rem  <= '0;
                    r_cnt  <= CW'(WIDTH_P);
                    r_busy <= 1'b1;
                end
                CALC: begin
                    r_dvd <= w_dvd_n;
                    r_rem <= w_rem_n;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_quot <= w_dvd_n;
                        r_remo <= w_rem_n;
                        r_dz   <= 1'b0;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_quot <= '1;
                    r_remo <= '0;
                    r_dz   <= 1'b1;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
            endcase
        end
    end
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_remo;
    assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_times_table_divider.sv
// tb_times_table_divider: self-checking bench for times_table_divider against a plain-arithmetic model
module tb_times_table_divider;
    logic clk;
    logic rst_n;
    int checks = 0;
    int errors = 0;
    times_table_divider_if #(.WIDTH_P(6), .WIDTH_D(3)) bus ();
    times_table_divider #(.WIDTH_P(6), .WIDTH_D(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Issue a one-cycle start pulse and count enabled edges until done; -1 when done never arrives.
    task automatic run_op(input logic [5:0] p, input logic [2:0] d, output int lat);
        bus.product = p;
        bus.divisor = d;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        if (!bus.done) lat = -1;
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        bus.enable = 1'b1;
        bus.start = 1'b0;
        bus.product = '0;
        bus.divisor = '0;
        tick();
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 000", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero});
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %0d want 0", bus.busy);
        end
    endtask
    task automatic test_basic();
        bus.product = 6'd42;
        bus.divisor = 3'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy[%0d]: got busy=%0d done=%0d want busy=1 done=0", k, bus.busy, bus.done);
            end
            if (k < 5) tick();
        end
        tick();
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 6'd7 || bus.remainder !== 3'd0 || bus.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got done=%0d busy=%0d q=%0d r=%0d dz=%0d want 1 0 7 0 0",
                     bus.done, bus.busy, bus.quotient, bus.remainder, bus.div_zero);
        end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %0d want 0", bus.done);
        end
    endtask
    task automatic test_sweep();
        int lat;
        logic [5:0] p;
        logic [2:0] d;
        for (int a = 1; a <= 7; a++) begin
            for (int b = 1; b <= 7; b++) begin
                p = 6'(a * b);
                d = 3'(b);
                run_op(p, d, lat);
                checks++;
                if (lat != 6 || int'(bus.quotient) != a || bus.remainder !== 3'd0 || bus.div_zero !== 1'b0) begin
                    errors++;
                    $display("FAIL sweep %0d/%0d: got lat=%0d q=%0d r=%0d dz=%0d want 6 %0d 0 0",
                             p, d, lat, bus.quotient, bus.remainder, bus.div_zero, a);
                end
            end
        end
        run_op(6'd47, 3'd5, lat);
        checks++;
        if (lat != 6 || bus.quotient !== 6'd9 || bus.remainder !== 3'd2) begin
            errors++;
            $display("FAIL sweep_47_5: got lat=%0d q=%0d r=%0d want 6 9 2", lat, bus.quotient, bus.remainder);
        end
        run_op(6'd63, 3'd1, lat);
        checks++;
        if (lat != 6 || bus.quotient !== 6'd63 || bus.remainder !== 3'd0) begin
            errors++;
            $display("FAIL sweep_63_1: got lat=%0d q=%0d r=%0d want 6 63 0", lat, bus.quotient, bus.remainder);
        end
    endtask
    task automatic test_div_zero();
        int lat;
        run_op(6'd5, 3'd0, lat);
        checks++;
        if (lat != 1 || bus.quotient !== 6'd63 || bus.remainder !== 3'd0 || bus.div_zero !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL div_zero: got lat=%0d q=%0d r=%0d dz=%0d busy=%0d want 1 63 0 1 0",
                     lat, bus.quotient, bus.remainder, bus.div_zero, bus.busy);
        end
        run_op(6'd12, 3'd4, lat);
        checks++;
        if (lat != 6 || bus.quotient !== 6'd3 || bus.remainder !== 3'd0 || bus.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_recover: got lat=%0d q=%0d r=%0d dz=%0d want 6 3 0 0",
                     lat, bus.quotient, bus.remainder, bus.div_zero);
        end
    endtask
    task automatic test_busy_ignore();
        int lat;
        int n;
        bus.product = 6'd20;
        bus.divisor = 3'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.product = 6'd9;
        bus.divisor = 3'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 3;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 6 || bus.done !== 1'b1 || bus.quotient !== 6'd6 || bus.remainder !== 3'd2) begin
            errors++;
            $display("FAIL busy_ignore: got lat=%0d done=%0d q=%0d r=%0d want 6 1 6 2",
                     lat, bus.done, bus.quotient, bus.remainder);
        end
        n = 0;
        repeat (12) begin
            tick();
            if (bus.done || bus.busy) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL busy_ignore_no_second: got %0d active cycles want 0", n);
        end
    endtask
    task automatic test_back_to_back();
        int lat;
        bus.product = 6'd10;
        bus.divisor = 3'd3;
        bus.start = 1'b1;
        tick();
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 6 || bus.quotient !== 6'd3 || bus.remainder !== 3'd1) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want 6 3 1", lat, bus.quotient, bus.remainder);
        end
        bus.product = 6'd50;
        bus.divisor = 3'd7;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 6'd3) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%0d done=%0d q=%0d want 1 0 3", bus.busy, bus.done, bus.quotient);
        end
        lat = 0;
        while (!bus.done && lat < 20) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 6 || bus.quotient !== 6'd7 || bus.remainder !== 3'd1) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d want 6 7 1", lat, bus.quotient, bus.remainder);
        end
    endtask
    task automatic test_enable_stall();
        int lat;
        run_op(6'd13, 3'd2, lat);
        checks++;
        if (lat != 6 || bus.quotient !== 6'd6 || bus.remainder !== 3'd1) begin
            errors++;
            $display("FAIL stall_pre: got lat=%0d q=%0d r=%0d want 6 6 1", lat, bus.quotient, bus.remainder);
        end
        bus.product = 6'd42;
        bus.divisor = 3'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        lat = 2;
        bus.enable = 1'b0;
        repeat (3) begin
            tick();
            lat++;
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 6'd6 || bus.remainder !== 3'd1 || bus.div_zero !== 1'b0) begin
                errors++;
                $display("FAIL stall_frozen: got busy=%0d done=%0d q=%0d r=%0d dz=%0d want 1 0 6 1 0",
                         bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero);
            end
        end
        bus.enable = 1'b1;
        while (!bus.done && lat < 30) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 9 || bus.quotient !== 6'd7 || bus.remainder !== 3'd0) begin
            errors++;
            $display("FAIL stall_result: got lat=%0d q=%0d r=%0d want 9 7 0", lat, bus.quotient, bus.remainder);
        end
        bus.enable = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL stall_done_hold: got %0d want 1", bus.done);
        end
        bus.enable = 1'b1;
        tick();
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL stall_done_release: got %0d want 0", bus.done);
        end
    endtask
    task automatic test_reset_midop();
        int lat;
        int n;
        bus.product = 6'd63;
        bus.divisor = 3'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero} !== 12'h0) begin
            errors++;
            $display("FAIL midop_reset: got %h want 000", {bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_zero});
        end
        tick();
        #3 rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            tick();
            if (bus.done || bus.busy) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL midop_no_done: got %0d active cycles want 0", n);
        end
        run_op(6'd35, 3'd7, lat);
        checks++;
        if (lat != 6 || bus.quotient !== 6'd5 || bus.remainder !== 3'd0 || bus.div_zero !== 1'b0) begin
            errors++;
            $display("FAIL midop_after: got lat=%0d q=%0d r=%0d dz=%0d want 6 5 0 0",
                     lat, bus.quotient, bus.remainder, bus.div_zero);
        end
    endtask
    task automatic test_random();
        int lat;
        int p;
        int d;
        int eq;
        int er;
        int edz;
        int elat;
        repeat (40) begin
            p = $urandom_range(0, 63);
            d = $urandom_range(0, 7);
            eq   = (d == 0) ? 63 : p / d;
            er   = (d == 0) ? 0 : p % d;
            edz  = (d == 0) ? 1 : 0;
            elat = (d == 0) ? 1 : 6;
            run_op(6'(p), 3'(d), lat);
            checks++;
            if (lat != elat || int'(bus.quotient) != eq || int'(bus.remainder) != er || int'(bus.div_zero) != edz) begin
                errors++;
                $display("FAIL random %0d/%0d: got lat=%0d q=%0d r=%0d dz=%0d want %0d %0d %0d %0d",
                         p, d, lat, bus.quotient, bus.remainder, bus.div_zero, elat, eq, er, edz);
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask
    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_div_zero();
        test_busy_ignore();
        test_back_to_back();
        test_enable_stall();
        test_reset_midop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
